// File: rtl/fact_pkg.sv
// fact_pkg: shared FSM state type, register offsets and default operand limit
// for the factorial MMIO accelerator.
`default_nettype none

package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OFF_N      = 2'b00;
  localparam logic [1:0] OFF_GO     = 2'b01;
  localparam logic [1:0] OFF_STATUS = 2'b10;
  localparam logic [1:0] OFF_RESULT = 2'b11;

  // 12! is the largest factorial that fits in 32 bits
  localparam int MAX_N_DEFAULT = 12;

endpackage

`default_nettype wire

// File: rtl/fact_core.sv
// fact_core: iterative factorial FSM, one multiply per cycle, with done/err flags
// and a held RESULT register.
`default_nettype none

module fact_core
  import fact_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int MAX_N      = MAX_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done_set
);

  localparam logic [N_WIDTH-1:0] MAX_N_W = N_WIDTH'(MAX_N);
  localparam logic [N_WIDTH-1:0] ONE_N   = N_WIDTH'(1);

  state_t                state;
  logic [N_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH-1:0] acc;

  // Asserted in the cycle whose closing edge raises done (error or completion)
  assign done_set = ((state != BUSY) && start && (n > MAX_N_W)) ||
                    ((state == BUSY) && (cnt <= ONE_N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done <= 1'b0;
            err  <= 1'b0;
            if (n > MAX_N_W) begin
              state  <= DONE;
              err    <= 1'b1;
              done   <= 1'b1;
              result <= '0;
            end else begin
              cnt   <= n;
              acc   <= DATA_WIDTH'(1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt <= ONE_N) begin
            result <= acc;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= acc * DATA_WIDTH'(cnt);
            cnt <= cnt - ONE_N;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fact_mmio_unit.sv
// fact_mmio_unit: register bank, start decode and read mux around fact_core.
// Optional completion interrupt enabled by defining FACT_IRQ_EN.
`default_nettype none

module fact_mmio_unit
  import fact_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int MAX_N      = MAX_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic [1:0]            A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD
`ifdef FACT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic [N_WIDTH-1:0]    n_reg;
  logic                  go_reg;
  logic                  go_write;
  logic                  start;
  logic                  done;
  logic                  err;
  logic                  done_set;
  logic [DATA_WIDTH-1:0] result;

  assign go_write = WE && (A == OFF_GO);
  // The core itself ignores start while BUSY
  assign start    = go_write && WD[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg  <= '0;
      go_reg <= 1'b0;
    end else if (WE) begin
      if (A == OFF_N)  n_reg  <= WD[N_WIDTH-1:0];
      if (A == OFF_GO) go_reg <= WD[0];
    end
  end

  fact_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_WIDTH    (N_WIDTH),
    .MAX_N      (MAX_N)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n_reg),
    .done     (done),
    .err      (err),
    .result   (result),
    .done_set (done_set)
  );

  always_comb begin
    RD = '0;
    case (A)
      OFF_N:      RD[N_WIDTH-1:0] = n_reg;
      OFF_GO:     RD[0]           = go_reg;
      OFF_STATUS: RD[1:0]         = {err, done};
      OFF_RESULT: RD              = result;
      default:    RD              = '0;
    endcase
  end

  logic unused_wd;
  assign unused_wd = ^WD[DATA_WIDTH-1:N_WIDTH];

`ifdef FACT_IRQ_EN
  // Setting wins over clearing so an error start still raises irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           irq <= 1'b0;
    else if (done_set) irq <= 1'b1;
    else if (go_write) irq <= 1'b0;
  end
`else
  logic unused_done_set;
  assign unused_done_set = done_set;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fact_mmio_unit.sv
// tb_fact_mmio_unit: scoreboard bench for fact_mmio_unit; expected results
// come from a factorial model and are checked when STATUS reports done.
`default_nettype none

module tb_fact_mmio_unit;
  import fact_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WE  = 1'b0;
  logic [1:0]  A   = 2'b00;
  logic [31:0] WD  = '0;
  logic [31:0] RD;
`ifdef FACT_IRQ_EN
  logic        irq;
`endif

  fact_mmio_unit #(.DATA_WIDTH(32), .N_WIDTH(4), .MAX_N(12)) dut (
    .clk (clk),
    .rst (rst),
    .WE  (WE),
    .A   (A),
    .WD  (WD),
    .RD  (RD)
`ifdef FACT_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc_count = 0;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fact_model(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    WE = 1'b1; A = a; WD = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic start_op(input int n);
    exp_t e;
    reg_write(OFF_N, 32'(n));
    reg_write(OFF_GO, 32'd1);
    e.t0  = cyc_count;
    e.err = (n > 12);
    e.res = (n > 12) ? 32'd0 : fact_model(n);
    e.lat = (n > 12) ? 0 : ((n == 0) ? 1 : n);
    sb.push_back(e);
  endtask

  task automatic wait_done();
    exp_t e;
    int   waited = 0;
    A = OFF_STATUS; #1;
    while (RD[0] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      A = OFF_STATUS; #1;
      waited++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (RD[0] !== 1'b1) begin
      check("done_timeout", {31'b0, RD[0]}, 32'd1);
      return;
    end
    check("latency", 32'(cyc_count - e.t0), 32'(e.lat));
    check("status", RD, {30'b0, e.err, 1'b1});
`ifdef FACT_IRQ_EN
    check("irq_with_done", {31'b0, irq}, 32'd1);
`endif
    A = OFF_RESULT; #1;
    check("result", RD, e.res);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      A = 2'(a); #1;
      check(tag, RD, 32'd0);
    end
`ifdef FACT_IRQ_EN
    check("irq_reset", {31'b0, irq}, 32'd0);
`endif
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset_rd");
    rst = 1'b0;

    // reset in the middle of a computation
    start_op(7);
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    sb.delete();
    check_all_zero("midbusy_reset_rd");
    @(negedge clk);
    rst = 1'b0;

    start_op(5);  wait_done();
    start_op(0);  wait_done();
    start_op(1);  wait_done();
    start_op(12); wait_done();

    // out-of-range operand, then recovery
    start_op(13); wait_done();
    start_op(3);  wait_done();

    // writes during BUSY must not restart the computation
    start_op(6);
    @(negedge clk);
    reg_write(OFF_GO, 32'd1);
    reg_write(OFF_N, 32'd2);
    wait_done();
    A = OFF_N;  #1; check("n_readback", RD, 32'd2);
    A = OFF_GO; #1; check("go_readback", RD, 32'd1);

`ifdef FACT_IRQ_EN
    reg_write(OFF_GO, 32'd0);
    A = OFF_STATUS; #1;
    check("irq_cleared", {31'b0, irq}, 32'd0);
    check("done_kept", RD, 32'd1);
`endif

    for (int k = 0; k < 6; k++) begin
      start_op(int'($urandom_range(0, 15)));
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fact_mmio_unit.md
# fact_mmio_unit

Memory-mapped factorial accelerator that responds on the I/O bus behind the system address decoder, occupying the 16-byte window at 0x800–0x80C. The CPU writes an operand and a go command through the decoder's per-device write enable, polls a status register, then reads back the 32-bit result. Contains a register bank, a read multiplexer and an iterative multiply FSM.

## Interface
- DATA_WIDTH, 32: width of bus data and result.
- N_WIDTH, 4: width of the operand n.
- MAX_N, 12: largest n whose factorial fits in DATA_WIDTH; larger n flags an error.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- WE  input  1  write enable from the decoder (the 0x800 window enable).
- A  input  2  word offset, bus address bits [3:2].
- WD  input  DATA_WIDTH  write data.
- RD  output  DATA_WIDTH  read data, combinational from A.
- irq  output  1  completion interrupt; present only with FACT_IRQ_EN.

## Operation
- Register map, by A:
  - 00 N: read/write, bits [N_WIDTH-1:0]; upper bits read as 0.
  - 01 GO: read/write bit 0; read returns the last value written.
  - 10 STATUS: read-only, {0…, err, done}.
  - 11 RESULT: read-only, DATA_WIDTH.
- Writes to STATUS and RESULT are ignored.
- FSM states:
  - IDLE: wait for a start.
  - BUSY: perform one multiply per cycle.
  - DONE: result valid; accepts a new start.
- Start condition: WE=1, A=01, WD[0]=1, and state is IDLE or DONE.
  - On start, clear done and err.
  - If N > MAX_N: go straight to DONE, set err=1 and done=1, set RESULT=0.
  - Otherwise: cnt←N, acc←1, go to BUSY.
- BUSY:
  - If cnt ≤ 1: RESULT←acc, done←1, go to DONE.
  - Otherwise: acc←acc·cnt (truncated to DATA_WIDTH), cnt←cnt−1.
- A start while BUSY is ignored; the GO register still updates.
- Writing N while BUSY changes the N register only; the running computation uses the latched cnt.
- GO writes with WD[0]=0 update the GO register only; no FSM effect.
- Reset values: all registers 0, state IDLE, RD reflects these zeros, irq=0.
- rst asserted mid-computation aborts immediately to IDLE with done=0 and RESULT=0.

## Timing
- Start is sampled at rising edge e0.
- done=1 and RESULT are valid after edge e0+max(N,1).
  - N=0 → result 1 at e0+1.
  - N=5 → result 120 at e0+5.
- Error case: done=1 and err=1 are visible immediately after e0.
- RD is combinational, so it is valid in the same cycle A changes. Reading STATUS in the cycle of the completing edge returns the pre-edge value.
- Simultaneous start and completion cannot occur: a start is only accepted when state is not BUSY.

## Configuration
- FACT_IRQ_EN defined:
  - irq port exists.
  - irq is set on the edge that sets done (including the error case).
  - irq is cleared by any GO write or by rst.
- FACT_IRQ_EN undefined: no irq port and no irq flop; all other behaviour is identical.

## Structure
- Shared package fact_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - register offset constants (OFF_N=2'b00, OFF_GO=2'b01, OFF_STATUS=2'b10, OFF_RESULT=2'b11);
  - MAX_N default.
- Sub-module fact_core contains the FSM, cnt/acc datapath, done/err/RESULT. Its interface is start, n, done, err, result.
- The top level contains the register bank, start decode, read mux and the optional irq.

## Test plan
- Reset mid-BUSY (N=7, assert rst two cycles after start) → state IDLE, STATUS=0, RESULT=0, RD=0 on all offsets.
- Write N=5, GO=1 → STATUS=0 for 4 cycles, then STATUS=0x1 and RESULT=120 exactly 5 edges after the GO write.
- N=0 and N=1 → RESULT=1 after 1 edge; N=12 → RESULT=479001600 after 12 edges.
- N=13, GO=1 → STATUS=0x3 after 1 edge, RESULT=0; a following N=3 start clears err and gives RESULT=6.
- Second GO=1 and N=2 written while a N=6 start is BUSY → RESULT=720, no restart; readback of N=2 and GO=1.
- With FACT_IRQ_EN: irq rises with done; a GO write of 0 clears irq while done stays 1.
